mulmod_barrett_pipe: RTL
========================

Name: mulmod_barrett_pipe

Overview:
- Parametrised, fully pipelined modular multiplier using Barrett reduction. It is the successor to the fixed 22-bit MulMod.
- Adds generic width and modulus, configurable stage counts, a per-transaction mode (mulmod / reduce-only / pass), valid-ready flow control with stall, and a user tag carried alongside the data.
- Sits inside butterfly PEs of the NTT/FFT datapath. Throughput is one operation per cycle when not stalled.

Parameters:
- DATA_WIDTH, 22, operand/result width W.
- MODULUS, 4194241, reduction modulus q. Must satisfy 2^(W-1) < q < 2^W; elaboration error otherwise.
- MUL_STAGES, 1, register stages in the W×W multiplier (≥1).
- BR_STAGES, 2, register stages in the Barrett reducer (≥2).
- TAG_WIDTH, 4, sideband tag width.
- Local MU = floor(2^(2W) / MODULUS), computed at elaboration, W+1 bits.
- Local LAT = MUL_STAGES + BR_STAGES.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset. Synchronous, active-high: asserted when 1. The name follows the codebase; the polarity is as stated.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts input this cycle.
- mode  in  2  00 = A*B mod q; 01 = {A_in,B_in} mod q (reduce-only, the bypass successor); 10 = pass A_in unchanged; 11 = reserved, treated as 00.
- A_in  in  W  operand A, or upper half of reduce input.
- B_in  in  W  operand B, or lower half of reduce input.
- tag_in  in  TAG_WIDTH  user tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  W  reduced result.
- tag_out  out  TAG_WIDTH  tag matching result.

Behaviour:
- Reset (rst_n=1 at a clk edge): all stage valid bits clear; out_valid=0, result=0, tag_out=0. in_ready=1 in the cycle after reset. Data registers may also clear. A reset mid-operation discards every in-flight transaction.
- Stall: advance = ~out_valid | out_ready. in_ready = advance, combinational.
- Pipeline movement: all stages shift together only when advance=1. A transaction is accepted when in_valid & in_ready.
- Bubbles propagate as valid=0. Whether a bubble is squeezed out is implementation-defined; the data order must be preserved.
- Latency: exactly LAT cycles from acceptance to out_valid when out_ready is held at 1. Defaults give 3.
- Holding: while out_valid=1 & out_ready=0, result and tag_out hold stable and no stage changes.
- Mode and tag travel down the pipeline with the data. All modes have identical latency, so ordering is never reordered.
- Mode 00: x = A_in*B_in, 2W bits. Requires A_in, B_in < q; for out-of-range inputs the result is unspecified but must still be < 2^W.
- Mode 01: x = {A_in,B_in}. Any x < 2^(2W) is valid; the multiplier stages carry x unchanged as a delay.
- Barrett reduction:
  - q1 = x >> (W-1)
  - q3 = (q1*MU) >> (W+1)
  - r = (x - q3*q) mod 2^(W+2)
  - then at most two conditional subtractions of q, giving 0 ≤ result < q.
  - All intermediates are sized so none overflows.
- Mode 10: result = A_in, not reduced, delayed LAT cycles.
- Simultaneous accept and emit in the same cycle is legal, so full throughput is 1 per cycle.
- in_valid with in_ready=0: the input is not captured. The source must hold it, which is the standard valid-ready rule.

Test Plan:
- Reset, then mode 00, A=q-1=4194240, B=q-1, out_ready=1 -> out_valid exactly 3 cycles after accept, result=1.
- Mode 00 sweep: A=0,B=123 -> 0; A=1,B=q-1 -> 4194240; A=2^21,B=2 -> 2^22 mod q = 63. Back-to-back every cycle; tags 0..15 return in order.
- Mode 01: {A,B} equal to q -> 0; equal to 2q+5 -> 5; equal to 2^44-1 -> (2^44-1) mod q, checked against the reference model. Mode 10: A=4194303 -> 4194303 unreduced.
- Stall: stream 8 ops, drop out_ready low for 5 cycles mid-stream -> in_ready=0 while out_valid=1; result/tag stable; no loss or duplication; order preserved.
- Reset mid-stream with 3 ops in flight -> out_valid=0 next cycle; none of those ops emerge afterwards.
- Random: 10^5 mixed-mode ops with random in_valid/out_ready on W=22 and W=14 (q=12289) builds -> all results match the golden model; result < q for modes 00/01.

Source files
------------

// File: rtl/mulmod_barrett_pipe.sv
// Pipelined modular multiplier (A*B mod q) using Barrett reduction, with reduce-only and
// pass modes, valid/ready flow control and a tag carried alongside each result.
module mulmod_barrett_pipe #(
    parameter int DATA_WIDTH = 22,
    parameter int MODULUS    = 4194241,
    parameter int MUL_STAGES = 1,
    parameter int BR_STAGES  = 2,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] A_in,
    input  logic [DATA_WIDTH-1:0] B_in,
    input  logic [TAG_WIDTH-1:0]  tag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic [TAG_WIDTH-1:0]  tag_out
);
    localparam int W = DATA_WIDTH;
    localparam logic [2*W:0] POW_2W  = (2*W+1)'(1) << (2*W);
    localparam logic [2*W:0] MU_FULL = POW_2W / (2*W+1)'(MODULUS);
    localparam logic [W:0]   MU      = MU_FULL[W:0];
    localparam logic [W+1:0] Q       = (W+2)'(MODULUS);

    if (longint'(MODULUS) <= (longint'(1) << (W-1)) || longint'(MODULUS) >= (longint'(1) << W)) begin : g_bad_modulus
        $error("MODULUS must lie strictly between 2^(W-1) and 2^W");
    end
    if (MUL_STAGES < 1 || BR_STAGES < 2) begin : g_bad_stages
        $error("MUL_STAGES must be >= 1 and BR_STAGES >= 2");
    end

    // Multiplier stages: x is the 2W-bit value to be reduced (or the pass operand).
    logic                 m_v    [MUL_STAGES];
    logic [1:0]           m_mode [MUL_STAGES];
    logic [TAG_WIDTH-1:0] m_tag  [MUL_STAGES];
    logic [2*W-1:0]       m_x    [MUL_STAGES];

    // First Barrett stage: low W+2 bits of x plus the quotient estimate q3.
    logic                 b_v;
    logic [1:0]           b_mode;
    logic [TAG_WIDTH-1:0] b_tag;
    logic [W+1:0]         b_x;
    logic [W:0]           b_q3;

    // Remaining Barrett stages carry the final W-bit result.
    logic                 r_v   [BR_STAGES-1];
    logic [TAG_WIDTH-1:0] r_tag [BR_STAGES-1];
    logic [W-1:0]         r_res [BR_STAGES-1];

    logic           advance;
    logic [2*W-1:0] x_in;
    logic [2*W-1:0] mul_x;
    logic [W:0]     q1;
    logic [W:0]     q3;
    logic [W+1:0]   r0, r1, r2;
    logic [W-1:0]   red;

    assign out_valid = r_v[BR_STAGES-2];
    assign result    = r_res[BR_STAGES-2];
    assign tag_out   = r_tag[BR_STAGES-2];
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;

    always_comb begin
        x_in = (2*W)'(A_in) * (2*W)'(B_in);
        case (mode)
            2'b01:   x_in = {A_in, B_in};
            2'b10:   x_in = (2*W)'(A_in);
            default: x_in = (2*W)'(A_in) * (2*W)'(B_in);
        endcase
    end

    assign mul_x = m_x[MUL_STAGES-1];
    assign q1    = mul_x[2*W-1:W-1];
    assign q3    = (W+1)'(((2*W+2)'(q1) * (2*W+2)'(MU)) >> (W+1));

    // r < 3q always, so W+2 bits hold it and two subtractions finish the job.
    assign r0  = b_x - ((W+2)'(b_q3) * Q);
    assign r1  = (r0 >= Q) ? r0 - Q : r0;
    assign r2  = (r1 >= Q) ? r1 - Q : r1;
    assign red = (b_mode == 2'b10) ? b_x[W-1:0] : W'(r2);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                m_v[i]    <= 1'b0;
                m_mode[i] <= '0;
                m_tag[i]  <= '0;
                m_x[i]    <= '0;
            end
            b_v    <= 1'b0;
            b_mode <= '0;
            b_tag  <= '0;
            b_x    <= '0;
            b_q3   <= '0;
            for (int i = 0; i < BR_STAGES-1; i++) begin
                r_v[i]   <= 1'b0;
                r_tag[i] <= '0;
                r_res[i] <= '0;
            end
        end else if (advance) begin
            m_v[0]    <= in_valid;
            m_mode[0] <= mode;
            m_tag[0]  <= tag_in;
            m_x[0]    <= x_in;
            for (int i = 1; i < MUL_STAGES; i++) begin
                m_v[i]    <= m_v[i-1];
                m_mode[i] <= m_mode[i-1];
                m_tag[i]  <= m_tag[i-1];
                m_x[i]    <= m_x[i-1];
            end
            b_v    <= m_v[MUL_STAGES-1];
            b_mode <= m_mode[MUL_STAGES-1];
            b_tag  <= m_tag[MUL_STAGES-1];
            b_x    <= mul_x[W+1:0];
            b_q3   <= q3;
            r_v[0]   <= b_v;
            r_tag[0] <= b_tag;
            r_res[0] <= red;
            for (int i = 1; i < BR_STAGES-1; i++) begin
                r_v[i]   <= r_v[i-1];
                r_tag[i] <= r_tag[i-1];
                r_res[i] <= r_res[i-1];
            end
        end
    end
endmodule
